// File: rtl/bus_pkg.sv
// Shared interconnect definitions: address map, request entry layout and
// master-port FSM states.
package bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_BE_W   = BUS_DATA_W / 8;

    localparam logic [31:0] MAIN_MEM_BASE = 32'h0000_0000;
    localparam logic [31:0] MAIN_MEM_SIZE = 32'h1000_0000;
    localparam logic [31:0] GPU_MEM_BASE  = 32'h1000_0000;
    localparam logic [31:0] GPU_MEM_SIZE  = 32'h1000_0000;
    localparam logic [31:0] PERIPH_BASE   = 32'h2000_0000;
    localparam logic [31:0] PERIPH_SIZE   = 32'h0100_0000;
    localparam logic [31:0] CONFIG_BASE   = 32'h3000_0000;
    localparam logic [31:0] CONFIG_SIZE   = 32'h0001_0000;

    // Idle cycles between transfers so the interconnect's 2-stage pipeline drains.
    localparam int GAP_CYCLES = 2;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
        logic                  we;
        logic [BUS_BE_W-1:0]   be;
    } bus_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ERR,
        ST_GAP
    } bus_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10: begin
                    count <= count + 1'b1;
                    full  <= (count == CW'(DEPTH - 1));
                    empty <= 1'b0;
                end
                2'b01: begin
                    count <= count - 1'b1;
                    full  <= 1'b0;
                    empty <= (count == CW'(1));
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/bus_master_port.sv
// CPU-side master for interconnect port 0: buffers LSU requests and runs one
// bus transfer at a time, bounded by a timeout. Widths must match bus_pkg.
module bus_master_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    core_req_valid,
    output logic                    core_req_ready,
    input  logic [ADDR_WIDTH-1:0]   core_addr,
    input  logic [DATA_WIDTH-1:0]   core_wdata,
    input  logic                    core_we,
    input  logic [DATA_WIDTH/8-1:0] core_be,
    output logic                    core_rsp_valid,
    output logic [DATA_WIDTH-1:0]   core_rsp_rdata,
    output logic                    core_rsp_err,
    output logic                    bus_req,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    output logic                    bus_we,
    output logic [DATA_WIDTH/8-1:0] bus_be,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    input  logic                    bus_ready,
    output logic                    busy,
    output logic [15:0]             timeout_count
);

    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W  = 2;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    bus_req_t              req_in;
    bus_req_t              req_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [FCNT_W-1:0]     fifo_count;

    bus_state_e            state_q, state_n;
    logic [CNT_W-1:0]      cnt_q, cnt_n;
    logic [GAP_W-1:0]      gap_q, gap_n;
    logic                  bus_req_n;
    logic                  rsp_valid_n;
    logic                  rsp_err_n;
    logic [DATA_WIDTH-1:0] rsp_rdata_n;
    logic [15:0]           tmo_n;

    assign req_in.addr  = core_addr;
    assign req_in.wdata = core_wdata;
    assign req_in.we    = core_we;
    assign req_in.be    = core_be;

    sync_fifo #(
        .WIDTH ($bits(bus_req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (core_req_valid && core_req_ready),
        .wdata (req_in),
        .pop   (fifo_pop),
        .rdata (req_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // full is a register, so ready never depends on core_req_valid.
    assign core_req_ready = !fifo_full;
    assign busy           = (fifo_count != '0) || (state_q != ST_IDLE);

    always_comb begin
        state_n     = state_q;
        fifo_pop    = 1'b0;
        cnt_n       = cnt_q;
        gap_n       = gap_q;
        bus_req_n   = bus_req;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        rsp_rdata_n = '0;
        tmo_n       = timeout_count;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cnt_n    = '0;
                    if (req_head.be == '0) begin
                        state_n = ST_ERR;
                    end else begin
                        state_n   = ST_REQ;
                        bus_req_n = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                cnt_n = cnt_q + 1'b1;
                // A ready that lands on the timeout cycle still completes normally.
                if (bus_ready) begin
                    rsp_valid_n = 1'b1;
                    rsp_rdata_n = bus_we ? '0 : bus_rdata;
                    bus_req_n   = 1'b0;
                    gap_n       = '0;
                    state_n     = ST_GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b1;
                    if (timeout_count != 16'hFFFF) tmo_n = timeout_count + 16'd1;
                    bus_req_n   = 1'b0;
                    gap_n       = '0;
                    state_n     = ST_GAP;
                end
            end
            ST_ERR: begin
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b1;
                gap_n       = '0;
                state_n     = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_n = ST_IDLE;
                else                                 gap_n   = gap_q + 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            gap_q          <= '0;
            bus_req        <= 1'b0;
            bus_addr       <= '0;
            bus_wdata      <= '0;
            bus_we         <= 1'b0;
            bus_be         <= '0;
            core_rsp_valid <= 1'b0;
            core_rsp_err   <= 1'b0;
            core_rsp_rdata <= '0;
            timeout_count  <= '0;
        end else begin
            state_q        <= state_n;
            cnt_q          <= cnt_n;
            gap_q          <= gap_n;
            bus_req        <= bus_req_n;
            core_rsp_valid <= rsp_valid_n;
            core_rsp_err   <= rsp_err_n;
            core_rsp_rdata <= rsp_rdata_n;
            timeout_count  <= tmo_n;
            if (fifo_pop) begin
                bus_addr  <= req_head.addr & WORD_MASK;
                bus_wdata <= req_head.wdata;
                bus_we    <= req_head.we;
                bus_be    <= req_head.be;
            end
        end
    end

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: responses are scoreboarded against
// expectations queued when each request is driven.
module tb_bus_master_port;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          core_req_valid = 1'b0;
    logic          core_req_ready;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          core_we = 1'b0;
    logic [3:0]    core_be = '0;
    logic          core_rsp_valid;
    logic [DW-1:0] core_rsp_rdata;
    logic          core_rsp_err;
    logic          bus_req;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_we;
    logic [3:0]    bus_be;
    logic [DW-1:0] bus_rdata = '0;
    logic          bus_ready = 1'b0;
    logic          busy;
    logic [15:0]   timeout_count;

    always #5 clk = ~clk;

    bus_master_port #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (2),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .core_req_valid (core_req_valid),
        .core_req_ready (core_req_ready),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .core_we        (core_we),
        .core_be        (core_be),
        .core_rsp_valid (core_rsp_valid),
        .core_rsp_rdata (core_rsp_rdata),
        .core_rsp_err   (core_rsp_err),
        .bus_req        (bus_req),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_we         (bus_we),
        .bus_be         (bus_be),
        .bus_rdata      (bus_rdata),
        .bus_ready      (bus_ready),
        .busy           (busy),
        .timeout_count  (timeout_count)
    );

    int checks   = 0;
    int failures = 0;

    logic [32:0] exp_q[$];
    int          rd_idx = 0;

    // Monitor logs: responses, and per bus_req pulse its address, preceding low run and length.
    logic [32:0] rsp_log [64];
    int          rsp_n = 0;
    logic [31:0] addr_log [64];
    int          gap_log [64];
    int          high_log [64];
    int          rise_n = 0;
    int          fall_n = 0;
    logic        prev_req = 1'b0;
    int          low_run = 0;
    int          high_run = 0;

    always @(negedge clk) begin
        if (core_rsp_valid && rsp_n < 64) begin
            rsp_log[rsp_n] = {core_rsp_err, core_rsp_rdata};
            rsp_n++;
        end
        if (bus_req && !prev_req && rise_n < 64) begin
            addr_log[rise_n] = bus_addr;
            gap_log[rise_n]  = low_run;
            rise_n++;
            high_run = 0;
        end
        if (!bus_req && prev_req && fall_n < 64) begin
            high_log[fall_n] = high_run;
            fall_n++;
            low_run = 0;
        end
        if (bus_req) high_run++;
        else         low_run++;
        prev_req = bus_req;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic we,
                        input logic [3:0] be, input logic err, input logic [31:0] rd);
        int n = 0;
        core_req_valid = 1'b1;
        core_addr      = a;
        core_wdata     = d;
        core_we        = we;
        core_be        = be;
        while (!core_req_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", core_req_ready, 1);
        exp_q.push_back({err, rd});
        @(posedge clk);
        @(negedge clk);
        core_req_valid = 1'b0;
    endtask

    task automatic wait_bus_req(input string tag);
        int n = 0;
        while (!bus_req && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk(tag, bus_req, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic check_rsps(input string tag);
        logic [32:0] e;
        while (rd_idx < rsp_n) begin
            chk({tag, "_rsp_expected"}, exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({tag, "_rsp"}, rsp_log[rd_idx], e);
            end
            rd_idx++;
        end
        chk({tag, "_rsp_missing"}, exp_q.size(), 0);
    endtask

    int base;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", core_req_ready, 1);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_rsp_valid", core_rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tmo", timeout_count, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic read, slave ready on the 2nd REQ cycle
        bus_rdata = 32'hDEAD_BEEF;
        send(32'h0000_0104, 32'h0, 1'b0, 4'hF, 1'b0, 32'hDEAD_BEEF);
        wait_bus_req("rd_req");
        chk("rd_addr", bus_addr, 32'h0000_0104);
        chk("rd_we", bus_we, 0);
        chk("rd_be", bus_be, 4'hF);
        @(negedge clk);
        chk("rd_req_hold", bus_req, 1);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        chk("rd_rsp_pulse", core_rsp_valid, 1);
        chk("rd_gap1", bus_req, 0);
        @(negedge clk);
        chk("rd_rsp_single", core_rsp_valid, 0);
        chk("rd_gap2", bus_req, 0);
        wait_idle("rd_idle");
        check_rsps("rd");
        chk("rd_req_cycles", high_log[fall_n-1], 2);

        // Back-to-back writes, slave always ready
        bus_ready = 1'b1;
        bus_rdata = 32'h1234_5678;
        base = rise_n;
        send(32'h0000_1000, 32'hA1, 1'b1, 4'hF, 1'b0, 32'h0);
        send(32'h0000_1004, 32'hA2, 1'b1, 4'hF, 1'b0, 32'h0);
        send(32'h0000_1008, 32'hA3, 1'b1, 4'hF, 1'b0, 32'h0);
        chk("wr_ready_full", core_req_ready, 0);
        wait_idle("wr_idle");
        check_rsps("wr");
        chk("wr_bus_cycles", rise_n - base, 3);
        chk("wr_addr0", addr_log[base], 32'h0000_1000);
        chk("wr_addr1", addr_log[base+1], 32'h0000_1004);
        chk("wr_addr2", addr_log[base+2], 32'h0000_1008);
        chk("wr_gap1", gap_log[base+1], 3);
        chk("wr_gap2", gap_log[base+2], 3);

        // Timeout, then a normal request
        bus_ready = 1'b0;
        base = fall_n;
        send(32'h0000_0200, 32'h0, 1'b0, 4'hF, 1'b1, 32'h0);
        wait_idle("tmo_idle");
        check_rsps("tmo");
        chk("tmo_req_cycles", high_log[base], TMO);
        chk("tmo_count", timeout_count, 1);
        bus_ready = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        send(32'h0000_0204, 32'h0, 1'b0, 4'hF, 1'b0, 32'hCAFE_F00D);
        wait_idle("post_tmo_idle");
        check_rsps("post_tmo");

        // Ready on the exact timeout cycle, then stray ready through GAP/IDLE
        bus_ready = 1'b0;
        bus_rdata = 32'h0BAD_CAFE;
        base = fall_n;
        send(32'h0000_0300, 32'h0, 1'b0, 4'hF, 1'b0, 32'h0BAD_CAFE);
        wait_bus_req("race_req");
        repeat (TMO - 1) @(negedge clk);
        bus_ready = 1'b1;
        @(negedge clk);
        chk("race_rsp_pulse", core_rsp_valid, 1);
        repeat (4) @(negedge clk);
        bus_ready = 1'b0;
        wait_idle("race_idle");
        repeat (3) @(negedge clk);
        check_rsps("race");
        chk("race_req_cycles", high_log[base], TMO);
        chk("race_tmo_count", timeout_count, 1);

        // Zero byte enables: error one cycle after pop, no bus cycle
        base = rise_n;
        send(32'h0000_0400, 32'h0, 1'b0, 4'h0, 1'b1, 32'h0);
        @(negedge clk);
        chk("be0_no_rsp_yet", core_rsp_valid, 0);
        @(negedge clk);
        chk("be0_rsp_pulse", core_rsp_valid, 1);
        chk("be0_no_req", bus_req, 0);
        wait_idle("be0_idle");
        check_rsps("be0");
        chk("be0_no_bus_cycle", rise_n - base, 0);
        chk("be0_tmo_count", timeout_count, 1);

        // Address alignment
        bus_ready = 1'b1;
        send(32'h0C00_0003, 32'h55AA_55AA, 1'b1, 4'h3, 1'b0, 32'h0);
        wait_bus_req("align_req");
        chk("align_addr", bus_addr, 32'h0C00_0000);
        chk("align_be", bus_be, 4'h3);
        chk("align_wdata", bus_wdata, 32'h55AA_55AA);
        chk("align_we", bus_we, 1);
        wait_idle("align_idle");
        check_rsps("align");

        // Reset mid-REQ with two requests buffered
        bus_ready = 1'b0;
        send(32'h0000_0500, 32'h0, 1'b0, 4'hF, 1'b0, 32'h0);
        send(32'h0000_0504, 32'h0, 1'b0, 4'hF, 1'b0, 32'h0);
        send(32'h0000_0508, 32'h0, 1'b0, 4'hF, 1'b0, 32'h0);
        chk("mid_req_active", bus_req, 1);
        chk("mid_fifo_full", core_req_ready, 0);
        #1 rst = 1'b1;
        #1;
        chk("mid_req_drop", bus_req, 0);
        chk("mid_ready", core_req_ready, 1);
        chk("mid_busy", busy, 0);
        exp_q.delete();
        rd_idx = rsp_n;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_rsps("mid_rst");
        chk("mid_post_ready", core_req_ready, 1);
        chk("mid_post_busy", busy, 0);
        chk("mid_post_req", bus_req, 0);
        chk("mid_post_tmo", timeout_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
